// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares one single-ported memory between the LC3 fetch
// port and data port. Data has priority, with instruction starvation bounded
// by a burst counter, and a watchdog aborts accesses the memory never answers.
//
// state  | meaning
// IDLE   | no access; arbitrate the requests sampled this cycle
// I_ACC  | instruction read in flight, mem_en high
// D_ACC  | data read or write in flight, mem_en high
// RESP   | one-cycle completion pulse to the served requester
module lc3_mem_arbiter #(
   parameter int unsigned DATA_BURST_MAX = 4,
   parameter int unsigned TIMEOUT        = 64,
   parameter logic [15:0] ERR_WORD       = 16'hDEAD
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        I_macc,
   input  logic [15:0] pc,
   input  logic        instrmem_rd,
   input  logic        D_macc,
   input  logic [15:0] Data_addr,
   input  logic [15:0] Data_din,
   input  logic        Data_rd,
   output logic [15:0] Instr_dout,
   output logic [15:0] Data_dout,
   output logic        complete_instr,
   output logic        complete_data,
   output logic        mem_en,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_din,
   input  logic [15:0] mem_dout,
   input  logic        mem_ready,
   output logic        timeout_err
);

   localparam int unsigned BURST_W = (DATA_BURST_MAX > 0) ? $clog2(DATA_BURST_MAX + 1) : 1;
   localparam int unsigned WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(DATA_BURST_MAX);
   localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_I_ACC = 2'd1,
      ST_D_ACC = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
   logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
   logic [15:0]        instr_dout_q, instr_dout_d;
   logic [15:0]        data_dout_q, data_dout_d;
   logic [15:0]        mem_addr_q, mem_addr_d;
   logic [15:0]        mem_din_q, mem_din_d;
   logic               mem_rd_q, mem_rd_d;
   logic               mem_en_q, mem_en_d;
   logic               complete_instr_q, complete_instr_d;
   logic               complete_data_q, complete_data_d;
   logic               timeout_err_q, timeout_err_d;

   logic i_req;
   logic in_acc;
   logic wd_expire;
   logic grant_i;
   logic grant_d;

   // instrmem_rd qualifies the fetch request so a stray I_macc alone never wins
   assign i_req     = I_macc & instrmem_rd;
   assign in_acc    = (state_q == ST_I_ACC) || (state_q == ST_D_ACC);
   assign wd_expire = in_acc && !mem_ready && (wd_cnt_q == WD_LAST);

   // State and all registered outputs; reset aborts any access with no pulse
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q          <= ST_IDLE;
         burst_cnt_q      <= '0;
         wd_cnt_q         <= '0;
         instr_dout_q     <= '0;
         data_dout_q      <= '0;
         mem_addr_q       <= '0;
         mem_din_q        <= '0;
         mem_rd_q         <= 1'b0;
         mem_en_q         <= 1'b0;
         complete_instr_q <= 1'b0;
         complete_data_q  <= 1'b0;
         timeout_err_q    <= 1'b0;
      end else begin
         state_q          <= state_d;
         burst_cnt_q      <= burst_cnt_d;
         wd_cnt_q         <= wd_cnt_d;
         instr_dout_q     <= instr_dout_d;
         data_dout_q      <= data_dout_d;
         mem_addr_q       <= mem_addr_d;
         mem_din_q        <= mem_din_d;
         mem_rd_q         <= mem_rd_d;
         mem_en_q         <= mem_en_d;
         complete_instr_q <= complete_instr_d;
         complete_data_q  <= complete_data_d;
         timeout_err_q    <= timeout_err_d;
      end
   end

   // Arbitration and next state: data wins unless its burst allowance is spent
   always_comb begin
      state_d = state_q;
      grant_i = 1'b0;
      grant_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (D_macc && (!i_req || (burst_cnt_q < BURST_MAX))) begin
               grant_d = 1'b1;
               state_d = ST_D_ACC;
            end else if (i_req) begin
               grant_i = 1'b1;
               state_d = ST_I_ACC;
            end
         end
         ST_I_ACC, ST_D_ACC: begin
            if (mem_ready || wd_expire) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output datapath: latch the winner on grant, capture read data on completion
   always_comb begin
      burst_cnt_d      = burst_cnt_q;
      wd_cnt_d         = wd_cnt_q;
      instr_dout_d     = instr_dout_q;
      data_dout_d      = data_dout_q;
      mem_addr_d       = mem_addr_q;
      mem_din_d        = mem_din_q;
      mem_rd_d         = mem_rd_q;
      mem_en_d         = (state_d == ST_I_ACC) || (state_d == ST_D_ACC);
      complete_instr_d = (state_q == ST_I_ACC) && (state_d == ST_RESP);
      complete_data_d  = (state_q == ST_D_ACC) && (state_d == ST_RESP);
      timeout_err_d    = wd_expire;

      if (grant_i) begin
         mem_addr_d  = pc;
         mem_rd_d    = 1'b1;
         burst_cnt_d = '0;
         wd_cnt_d    = '0;
      end

      if (grant_d) begin
         mem_addr_d = Data_addr;
         mem_din_d  = Data_din;
         mem_rd_d   = Data_rd;
         wd_cnt_d   = '0;
         if (!i_req) begin
            burst_cnt_d = '0;
         end else if (burst_cnt_q != BURST_MAX) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
         end
      end

      if (in_acc) begin
         wd_cnt_d = wd_cnt_q + 1'b1;
         if (mem_ready) begin
            if (state_q == ST_I_ACC) begin
               instr_dout_d = mem_dout;
            end else if (mem_rd_q) begin
               data_dout_d = mem_dout;
            end
         end else if (wd_expire) begin
            if (state_q == ST_I_ACC) begin
               instr_dout_d = ERR_WORD;
            end else if (mem_rd_q) begin
               data_dout_d = ERR_WORD;
            end
         end
      end
   end

   assign Instr_dout     = instr_dout_q;
   assign Data_dout      = data_dout_q;
   assign mem_addr       = mem_addr_q;
   assign mem_din        = mem_din_q;
   assign mem_rd         = mem_rd_q;
   assign mem_en         = mem_en_q;
   assign complete_instr = complete_instr_q;
   assign complete_data  = complete_data_q;
   assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: a transaction-level model predicts every output
// each cycle from the requests and memory responses the bench applies.
module tb_lc3_mem_arbiter;

   localparam int          TMO = 64;
   localparam int          DBM = 4;
   localparam logic [15:0] ERR = 16'hDEAD;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        I_macc = 1'b0;
   logic [15:0] pc = '0;
   logic        instrmem_rd = 1'b0;
   logic        D_macc = 1'b0;
   logic [15:0] Data_addr = '0;
   logic [15:0] Data_din = '0;
   logic        Data_rd = 1'b0;
   logic [15:0] Instr_dout;
   logic [15:0] Data_dout;
   logic        complete_instr;
   logic        complete_data;
   logic        mem_en;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [15:0] mem_din;
   logic [15:0] mem_dout = 16'h5A5A;
   logic        mem_ready = 1'b0;
   logic        timeout_err;

   always #5 clock = ~clock;

   lc3_mem_arbiter #(.DATA_BURST_MAX(DBM), .TIMEOUT(TMO), .ERR_WORD(ERR)) dut (
      .clock(clock), .reset(reset),
      .I_macc(I_macc), .pc(pc), .instrmem_rd(instrmem_rd),
      .D_macc(D_macc), .Data_addr(Data_addr), .Data_din(Data_din), .Data_rd(Data_rd),
      .Instr_dout(Instr_dout), .Data_dout(Data_dout),
      .complete_instr(complete_instr), .complete_data(complete_data),
      .mem_en(mem_en), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout), .mem_ready(mem_ready), .timeout_err(timeout_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // model: ph 0 = nothing in flight, 1 = memory access running, 2 = answer cycle
   int          ph, side, acc_n, burst;
   logic [15:0] e_idout, e_ddout, e_addr, e_din;
   logic        e_rd, e_en, e_ci, e_cd, e_to;
   string       grants;

   // bench-side memory and requester behaviour
   int          ready_at = 1;
   logic [15:0] rd_word = 16'h0;
   bit          idle_rdy = 1'b0;
   bit          auto_drop = 1'b1;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      ph = 0; side = 0; acc_n = 0; burst = 0;
      e_idout = '0; e_ddout = '0; e_addr = '0; e_din = '0;
      e_rd = 0; e_en = 0; e_ci = 0; e_cd = 0; e_to = 0;
   endtask

   task automatic model_finish();
      ph = 2;
      if (side == 1) e_ci = 1'b1;
      else           e_cd = 1'b1;
   endtask

   // advance the model across one clock edge using the inputs seen at that edge
   task automatic model_edge();
      if (!reset) begin
         model_reset();
      end else begin
         e_ci = 0; e_cd = 0; e_to = 0;
         if (ph == 2) begin
            ph = 0;
         end else if (ph == 1) begin
            acc_n++;
            if (mem_ready) begin
               if (side == 1)  e_idout = mem_dout;
               else if (e_rd)  e_ddout = mem_dout;
               model_finish();
            end else if (acc_n == TMO) begin
               if (side == 1)  e_idout = ERR;
               else if (e_rd)  e_ddout = ERR;
               e_to = 1'b1;
               model_finish();
            end
         end else begin
            if (D_macc && (!I_macc || burst < DBM)) begin
               side = 2; ph = 1; acc_n = 0;
               burst = I_macc ? ((burst < DBM) ? burst + 1 : DBM) : 0;
               e_addr = Data_addr; e_din = Data_din; e_rd = Data_rd;
               grants = {grants, "D"};
            end else if (I_macc) begin
               side = 1; ph = 1; acc_n = 0; burst = 0;
               e_addr = pc; e_rd = 1'b1;
               grants = {grants, "I"};
            end
         end
         e_en = (ph == 1);
      end
   endtask

   task automatic compare_all();
      chk("instr_dout", Instr_dout, e_idout);
      chk("data_dout", Data_dout, e_ddout);
      chk("mem_en", {15'd0, mem_en}, {15'd0, e_en});
      chk("complete_instr", {15'd0, complete_instr}, {15'd0, e_ci});
      chk("complete_data", {15'd0, complete_data}, {15'd0, e_cd});
      chk("timeout_err", {15'd0, timeout_err}, {15'd0, e_to});
      chk("complete_excl", {15'd0, complete_instr & complete_data}, 16'd0);
      if (e_en) begin
         chk("mem_addr", mem_addr, e_addr);
         chk("mem_rd", {15'd0, mem_rd}, {15'd0, e_rd});
         if (!e_rd) chk("mem_din", mem_din, e_din);
      end
   endtask

   // memory responder and requester release, driven from the model's view
   task automatic drive_env();
      if (auto_drop && e_ci) begin I_macc = 1'b0; instrmem_rd = 1'b0; end
      if (auto_drop && e_cd) D_macc = 1'b0;
      if (ph == 1 && ready_at != 0 && acc_n + 1 == ready_at) begin
         mem_ready = 1'b1; mem_dout = rd_word;
      end else if (ph != 1 && idle_rdy) begin
         mem_ready = 1'b1; mem_dout = 16'h1111;
      end else begin
         mem_ready = 1'b0; mem_dout = 16'h5A5A;
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
      model_edge();
      compare_all();
      drive_env();
   endtask

   task automatic wait_done(input int bound, output int n);
      n = 0;
      for (int k = 0; k < bound; k++) begin
         cyc();
         n++;
         if (complete_instr || complete_data) break;
      end
      if (!(complete_instr || complete_data)) chk("wait_done_bound", 16'd0, 16'd1);
   endtask

   int n, lat, en_cyc, cd_seen;

   initial begin
      model_reset();
      grants = "";
      #12;
      chk("rst_instr_dout", Instr_dout, 16'h0);
      chk("rst_data_dout", Data_dout, 16'h0);
      chk("rst_mem_addr", mem_addr, 16'h0);
      chk("rst_mem_en", {15'd0, mem_en}, 16'h0);
      chk("rst_complete", {14'd0, complete_instr, complete_data}, 16'h0);
      @(posedge clock); #1;
      reset = 1'b1;
      cyc();

      // single instruction fetch
      pc = 16'h3000; I_macc = 1'b1; instrmem_rd = 1'b1; rd_word = 16'h1234; ready_at = 1;
      cyc();
      chk("t1_addr", mem_addr, 16'h3000);
      chk("t1_rd", {15'd0, mem_rd}, 16'h1);
      wait_done(20, n);
      lat = 2 + n;
      chk("t1_latency", lat[15:0], 16'd3);
      chk("t1_complete", {15'd0, complete_instr}, 16'h1);
      chk("t1_instr", Instr_dout, 16'h1234);
      cyc();
      chk("t1_pulse_end", {15'd0, complete_instr}, 16'h0);

      // data write, memory answers on the second access cycle
      Data_addr = 16'h4000; Data_din = 16'hBEEF; Data_rd = 1'b0; D_macc = 1'b1;
      rd_word = 16'h5555; ready_at = 2;
      cyc();
      chk("t2_rd", {15'd0, mem_rd}, 16'h0);
      chk("t2_din", mem_din, 16'hBEEF);
      wait_done(20, n);
      chk("t2_cycles", n[15:0], 16'd2);
      chk("t2_complete", {15'd0, complete_data}, 16'h1);
      chk("t2_dout_kept", Data_dout, 16'h0);
      cyc();

      // data read
      Data_addr = 16'h4001; Data_rd = 1'b1; D_macc = 1'b1; rd_word = 16'h7777; ready_at = 1;
      wait_done(20, n);
      chk("t2b_dout", Data_dout, 16'h7777);
      cyc();

      // both requesters held: four data grants then one instruction grant
      grants = ""; auto_drop = 1'b0; ready_at = 1; rd_word = 16'h2222;
      pc = 16'h3010; Data_addr = 16'h4100; Data_rd = 1'b1;
      I_macc = 1'b1; instrmem_rd = 1'b1; D_macc = 1'b1;
      for (int k = 0; k < 100; k++) begin
         cyc();
         if (grants.len() >= 10) break;
      end
      I_macc = 1'b0; instrmem_rd = 1'b0; D_macc = 1'b0; auto_drop = 1'b1;
      n_checks++;
      if (grants != "DDDDIDDDDI") begin
         n_fail++;
         $display("FAIL burst_order: got %s expected DDDDIDDDDI", grants);
      end
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (ph == 0) break;
      end
      chk("t3_idle", {15'd0, mem_en}, 16'h0);

      // watchdog abort on a data read
      Data_addr = 16'h5000; Data_rd = 1'b1; D_macc = 1'b1; ready_at = 0;
      en_cyc = 0;
      for (int k = 0; k < 200; k++) begin
         cyc();
         if (mem_en) en_cyc++;
         if (complete_data) break;
      end
      chk("t4_complete", {15'd0, complete_data}, 16'h1);
      chk("t4_timeout", {15'd0, timeout_err}, 16'h1);
      chk("t4_dout", Data_dout, 16'hDEAD);
      chk("t4_acc_cycles", en_cyc[15:0], 16'd64);
      cyc();
      chk("t4_back_idle", {14'd0, mem_en, timeout_err}, 16'h0);

      // mem_ready in IDLE ignored; pc change during access ignored
      idle_rdy = 1'b1;
      repeat (3) cyc();
      chk("t5_idle_en", {15'd0, mem_en}, 16'h0);
      idle_rdy = 1'b0;
      pc = 16'h3100; I_macc = 1'b1; instrmem_rd = 1'b1; rd_word = 16'hABCD; ready_at = 3;
      cyc();
      pc = 16'h7777;
      cyc();
      chk("t5_addr_frozen", mem_addr, 16'h3100);
      wait_done(20, n);
      chk("t5_instr", Instr_dout, 16'hABCD);
      chk("t5_addr_end", mem_addr, 16'h3100);
      cyc();

      // reset in the middle of a data access
      Data_addr = 16'h6000; Data_rd = 1'b1; D_macc = 1'b1; ready_at = 0;
      repeat (3) cyc();
      chk("t6_pre_en", {15'd0, mem_en}, 16'h1);
      #2 reset = 1'b0;
      #1;
      chk("t6_en", {15'd0, mem_en}, 16'h0);
      chk("t6_addr", mem_addr, 16'h0);
      chk("t6_data_dout", Data_dout, 16'h0);
      chk("t6_instr_dout", Instr_dout, 16'h0);
      chk("t6_complete", {14'd0, complete_instr, complete_data}, 16'h0);
      model_reset();
      D_macc = 1'b0;
      repeat (2) cyc();
      reset = 1'b1;
      cd_seen = 0;
      repeat (5) begin
         cyc();
         if (complete_data) cd_seen++;
      end
      chk("t6_no_stale", cd_seen[15:0], 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: got expired expected finish");
      $fatal(1);
   end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
- Shares one single-ported unified memory between the LC3 core's instruction-fetch port (I_macc/pc/instrmem_rd) and data port (D_macc/Data_addr/Data_din/Data_rd).
- Sits between the LC3 top level and the memory model.
- Serialises accesses, returns complete_instr/complete_data pulses to the pipeline controller, and enforces data-priority with bounded instruction starvation plus a watchdog timeout.

Parameters:
DATA_BURST_MAX, 4, max consecutive data grants while an instruction request is pending before instruction is forced.
TIMEOUT, 64, cycles in an access state without mem_ready before abort.
ERR_WORD, 16'hDEAD, read data returned on timeout abort.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
I_macc  input  1  instruction request, level, held until complete_instr.
pc  input  16  instruction address.
instrmem_rd  input  1  instruction read strobe (must be 1 when I_macc=1).
D_macc  input  1  data request, level, held until complete_data.
Data_addr  input  16  data address.
Data_din  input  16  write data.
Data_rd  input  1  1 = read, 0 = write.
Instr_dout  output  16  instruction word, registered.
Data_dout  output  16  data read word, registered.
complete_instr  output  1  one-cycle instruction completion pulse.
complete_data  output  1  one-cycle data completion pulse.
mem_en  output  1  memory access enable.
mem_rd  output  1  1 = read, 0 = write.
mem_addr  output  16  memory address.
mem_din  output  16  memory write data.
mem_dout  input  16  memory read data, valid with mem_ready.
mem_ready  input  1  memory access done this cycle.
timeout_err  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0: Instr_dout, Data_dout, mem_addr, mem_din, mem_en, mem_rd, complete_*, timeout_err. burst_cnt=0, wd_cnt=0.
- States: IDLE, I_ACC, D_ACC, RESP. All outputs registered.
- IDLE arbitration, sampled each cycle:
  - D_macc only -> D_ACC.
  - I_macc only -> I_ACC.
  - Both -> D_ACC if burst_cnt < DATA_BURST_MAX, else I_ACC.
  - Neither -> stay IDLE.
- On the grant edge, mem_addr/mem_din/mem_rd are latched from the winner and mem_en=1 from the first cycle of the ACC state.
  - I_ACC: mem_rd=1, mem_addr=pc.
  - D_ACC: mem_rd=Data_rd, mem_addr=Data_addr, mem_din=Data_din.
- Address/data are frozen for the whole access; requester input changes mid-access are ignored.
- ACC states:
  - mem_en held 1; wd_cnt increments each cycle.
  - On the edge where mem_ready=1: capture mem_dout into Instr_dout (I_ACC) or Data_dout (D_ACC, reads only; Data_dout unchanged on writes), drop mem_en, go to RESP.
  - If wd_cnt reaches TIMEOUT-1 with no mem_ready: load ERR_WORD into the read destination, pulse timeout_err for the RESP cycle, go to RESP.
- RESP (exactly one cycle):
  - complete_instr or complete_data=1 for the served side; requests ignored; then IDLE.
  - Requesters must deassert by the next cycle, otherwise the request is treated as new.
- Latency: a request with mem_ready on the first ACC cycle completes 3 cycles after request assertion (IDLE sample, ACC, RESP).
- burst_cnt:
  - Increments on a data grant while I_macc=1; saturates at DATA_BURST_MAX.
  - Clears on any instruction grant, or on a data grant with I_macc=0.
- wd_cnt clears on entry to any ACC state.
- mem_ready outside ACC states is ignored.
- Reset asserted mid-access: mem_en drops immediately; no completion pulse is issued for the aborted access.
- complete_instr and complete_data are never asserted together; mem_en is never 1 in IDLE or RESP.

Test Plan:
- Single instruction fetch: I_macc=1, pc=16'h3000, mem_ready on the first ACC cycle with mem_dout=16'h1234 -> mem_addr=16'h3000, mem_rd=1, complete_instr pulses 1 cycle, Instr_dout=16'h1234, 3-cycle latency.
- Data write: D_macc=1, Data_rd=0, Data_addr=16'h4000, Data_din=16'hBEEF -> mem_rd=0, mem_din=16'hBEEF, complete_data pulses, Data_dout unchanged.
- Simultaneous I_macc and D_macc held continuously -> exactly 4 data grants, then 1 instruction grant, then the pattern repeats; no two completes in the same cycle.
- mem_ready held 0 for 64 cycles on a data read -> timeout_err and complete_data pulse together, Data_dout=16'hDEAD, state returns to IDLE.
- reset pulled low during D_ACC -> mem_en=0 and all outputs 0 immediately; after release, IDLE with no stale complete_data.
- mem_ready=1 while IDLE, and pc changed mid-I_ACC -> ignored; mem_addr stays at the latched value.
